// File: rtl/vending_pkg.sv
// Shared types and constants for the vending datapath: FSM states, default
// actuation timings and the product/coin field widths used by top_maquina.
package vending_pkg;

  localparam int unsigned PULSE_CYCLES_DEF   = 4;
  localparam int unsigned GAP_CYCLES_DEF     = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  localparam int unsigned PROD_W = 2;
  localparam int unsigned COIN_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    VEND,
    WAIT_DROP,
    CHANGE,
    DONE,
    FAULT
  } state_t;

  // Largest of three timing parameters, used to size the shared counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dispensador_vending.sv
// Product/change dispenser: pulses the selected motor, waits for the drop
// sensor, then ejects change coins one timed pulse at a time.
module dispensador_vending
  import vending_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = PULSE_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       listo,
  input  logic [PROD_W-1:0]          producto,
  input  logic [COIN_W-1:0]          cambio,
  input  logic                       sensor_drop,
  input  logic                       clr_fault,
  output logic [(1 << PROD_W)-1:0]   motor,
  output logic                       coin_eject,
  output logic                       busy,
  output logic                       done,
  output logic                       fault
);

  localparam int unsigned NPROD = 1 << PROD_W;
  localparam int unsigned CNT_W =
    $clog2(max3(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [COIN_W-1:0]   coins_q, coins_d;
  logic                drop_seen_q, drop_seen_d;
  logic                gap_q, gap_d;
  logic                listo_q;

  logic [NPROD-1:0]    motor_q, motor_d;
  logic                coin_q, coin_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;

  logic                sensor_s;
  logic                rise_c;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync_drop (
    .clk (clk),
    .rst (rst),
    .d_i (sensor_drop),
    .q_o (sensor_s)
  );

  assign rise_c = listo & ~listo_q;

  // Next-state, datapath latches and next-state-decoded actuator outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    coins_d     = coins_q;
    drop_seen_d = drop_seen_q;
    gap_d       = gap_q;

    unique case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d     = VEND;
          prod_d      = producto;
          coins_d     = cambio;
          drop_seen_d = 1'b0;
          cnt_d       = '0;
        end
      end

      VEND: begin
        if (sensor_s) begin
          drop_seen_d = 1'b1;
        end
        if (cnt_q == PULSE_LAST) begin
          state_d = WAIT_DROP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_DROP: begin
        // A drop seen in the same cycle as the timeout still counts.
        if (drop_seen_q || sensor_s) begin
          cnt_d   = '0;
          gap_d   = 1'b0;
          state_d = (coins_q != '0) ? CHANGE : DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CHANGE: begin
        if (!gap_q) begin
          if (cnt_q == PULSE_LAST) begin
            cnt_d   = '0;
            coins_d = coins_q - COIN_W'(1);
            if (coins_q == COIN_W'(1)) begin
              state_d = DONE;
            end else begin
              gap_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            gap_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      FAULT: begin
        if (clr_fault) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    motor_d         = '0;
    motor_d[prod_d] = (state_d == VEND);
    coin_d          = (state_d == CHANGE) && !gap_d;
    busy_d          = (state_d != IDLE);
    done_d          = (state_d == DONE);
    fault_d         = (state_d == FAULT);
  end

  // listo_q resets high so a level already present at release is not a sale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      coins_q     <= '0;
      drop_seen_q <= 1'b0;
      gap_q       <= 1'b0;
      listo_q     <= 1'b1;
      motor_q     <= '0;
      coin_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      coins_q     <= coins_d;
      drop_seen_q <= drop_seen_d;
      gap_q       <= gap_d;
      listo_q     <= listo;
      motor_q     <= motor_d;
      coin_q      <= coin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign motor      = motor_q;
  assign coin_eject = coin_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_dispensador_vending.sv
// Bench for dispensador_vending: directed scenarios plus randomized sales,
// each checked cycle by cycle against a timeline built from the sale rules.
module tb_dispensador_vending;

  localparam int P    = 4;
  localparam int G    = 2;
  localparam int T    = 16;
  localparam int MAXN = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       listo;
  logic [1:0] producto;
  logic [1:0] cambio;
  logic       sensor_drop;
  logic       clr_fault;
  logic [3:0] motor;
  logic       coin_eject;
  logic       busy;
  logic       done;
  logic       fault;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] exp_motor [MAXN];
  logic       exp_coin  [MAXN];
  logic       exp_busy  [MAXN];
  logic       exp_done  [MAXN];
  logic       exp_fault [MAXN];

  always #5 clk = ~clk;

  dispensador_vending #(
    .PULSE_CYCLES   (P),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .listo       (listo),
    .producto    (producto),
    .cambio      (cambio),
    .sensor_drop (sensor_drop),
    .clr_fault   (clr_fault),
    .motor       (motor),
    .coin_eject  (coin_eject),
    .busy        (busy),
    .done        (done),
    .fault       (fault)
  );

  task automatic check(input string tag, input int k,
                       input logic [3:0] obs, input logic [3:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input int k, input logic [3:0] m,
                           input logic c, input logic b, input logic d,
                           input logic f);
    check({tag, ".motor"}, k, motor, m);
    check({tag, ".coin"},  k, {3'b000, coin_eject}, {3'b000, c});
    check({tag, ".busy"},  k, {3'b000, busy},       {3'b000, b});
    check({tag, ".done"},  k, {3'b000, done},       {3'b000, d});
    check({tag, ".fault"}, k, {3'b000, fault},      {3'b000, f});
  endtask

  // Expected outputs after edge k, where edge 0 samples the listo rise.
  // Sensor high at edges [sa,sb] is seen by the controller two edges later.
  task automatic build_expect(input int prod, input int coins,
                              input int sa, input int sb,
                              output int n, output int clr, output int rr);
    int l;
    int last;
    for (int k = 0; k < MAXN; k++) begin
      exp_motor[k] = 4'b0000;
      exp_coin[k]  = 1'b0;
      exp_busy[k]  = 1'b0;
      exp_done[k]  = 1'b0;
      exp_fault[k] = 1'b0;
    end
    l = -1;
    for (int e = 1; e <= P + T; e++) begin
      if (l < 0 && e - 2 >= sa && e - 2 <= sb) l = (e <= P + 1) ? P + 1 : e;
    end
    for (int k = 0; k < P; k++) exp_motor[k] = 4'b0001 << prod;
    clr = -1;
    rr  = -1;
    if (l < 0) begin
      for (int k = P + T; k < P + T + 3; k++) exp_fault[k] = 1'b1;
      clr  = P + T + 3;
      last = clr - 1;
      rr   = P + T + 1;
    end else if (coins == 0) begin
      exp_done[l] = 1'b1;
      last = l;
    end else begin
      for (int i = 0; i < coins; i++) begin
        for (int j = 0; j < P; j++) exp_coin[l + i * (P + G) + j] = 1'b1;
      end
      last = l + (coins - 1) * (P + G) + P;
      exp_done[last] = 1'b1;
      rr = P + 3;
    end
    for (int k = 0; k <= last; k++) exp_busy[k] = 1'b1;
    n = (last + 3 > sb + 4) ? last + 3 : sb + 4;
  endtask

  // Called at a negedge with listo low at the preceding edge.
  task automatic run_vend(input string tag, input int prod, input int coins,
                          input int sa, input int sb, input int abort_k);
    int n;
    int clr;
    int rr;
    build_expect(prod, coins, sa, sb, n, clr, rr);
    producto    = 2'(prod);
    cambio      = 2'(coins);
    listo       = 1'b1;
    sensor_drop = (sa <= 0 && sb >= 0);
    clr_fault   = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_all(tag, k, exp_motor[k], exp_coin[k], exp_busy[k], exp_done[k],
                exp_fault[k]);
      if (k == abort_k) begin
        #1 rst = 1'b1;
        #1 check_all({tag, ".rst"}, k, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        listo       = 1'b0;
        sensor_drop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          check_all({tag, ".post"}, j, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      listo       = (k + 1 <= 1) || (rr >= 0 && k + 1 >= rr && k + 1 <= rr + 1);
      sensor_drop = (k + 1 >= sa && k + 1 <= sb);
      clr_fault   = (k + 1 == clr);
      producto    = 2'($urandom);
      cambio      = 2'($urandom);
    end
  endtask

  initial begin
    int prod;
    int coins;
    int sa;
    int sb;

    rst         = 1'b1;
    listo       = 1'b1;
    producto    = 2'd0;
    cambio      = 2'd0;
    sensor_drop = 1'b0;
    clr_fault   = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // listo already high at release must not start a sale
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_all("listo_held", k, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    listo = 1'b0;
    @(negedge clk);

    run_vend("no_change",   2, 0, 3,   3,  -1);
    run_vend("three_coins", 1, 3, 1,   2,  -1);
    run_vend("timeout",     0, 2, 100, -1, -1);
    run_vend("after_fault", 3, 1, 4,   5,  -1);
    run_vend("late_drop",   1, 2, 12,  13, -1);
    run_vend("edge_drop",   2, 1, 18,  18, -1);
    run_vend("rst_coin2",   2, 2, 0,   0,  12);

    for (int r = 0; r < 24; r++) begin
      prod  = int'($urandom_range(0, 3));
      coins = int'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        sa = 100;
        sb = -1;
      end else begin
        sa = int'($urandom_range(0, 21));
        sb = sa + int'($urandom_range(0, 3));
      end
      run_vend("random", prod, coins, sa, sb, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
